// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative signed MUL (shift-add)
// and signed DIV (restoring) behind a start/busy/done handshake with latched operands.
module seq_alu #(
  parameter int W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic [2*W-1:0]   C,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(W);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // Rotates go through a doubled operand so s==0 needs no special case.
  function automatic logic [W-1:0] alu_single(input logic [4:0] f,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [SHW-1:0] s;
    logic [2*W-1:0] ror_v;
    logic [2*W-1:0] rol_v;
    logic [W-1:0]   r;
    s     = b[SHW-1:0];
    ror_v = {a, a} >> s;
    rol_v = {a, a} << s;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SHR:  r = a >> s;
      OP_SHRA: r = $signed(a) >>> s;
      OP_SHL:  r = a << s;
      OP_ROR:  r = ror_v[W-1:0];
      OP_ROL:  r = rol_v[2*W-1:W];
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NEG:  r = -b;
      OP_NOT:  r = ~b;
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [SHW:0]   cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   m_q, m_d;
  logic           is_div_q, is_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic [2*W-1:0] c_q, c_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;
  logic           il_q, il_d;

  logic [W:0]     mul_sum_s;
  logic [W:0]     div_sh_s;
  logic [W:0]     div_diff_s;
  logic [W-1:0]   nxt_hi_s;
  logic [W-1:0]   nxt_lo_s;
  logic [2*W-1:0] prod_s;

  // One iteration of either the shift-add multiplier or the restoring divider.
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    div_sh_s   = {hi_q, lo_q[W-1]};
    div_diff_s = div_sh_s - {1'b0, m_q};
    if (is_div_q) begin
      nxt_hi_s = div_diff_s[W] ? div_sh_s[W-1:0] : div_diff_s[W-1:0];
      nxt_lo_s = {lo_q[W-2:0], ~div_diff_s[W]};
    end else begin
      nxt_hi_s = mul_sum_s[W:1];
      nxt_lo_s = {mul_sum_s[0], lo_q[W-1:1]};
    end
    prod_s = {nxt_hi_s, nxt_lo_s};
  end

  // Control FSM and result/flag next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    c_d       = c_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    il_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            hi_d      = {W{1'b0}};
            lo_d      = mag(B);
            m_d       = mag(A);
            is_div_d  = 1'b0;
            neg_res_d = A[W-1] ^ B[W-1];
            neg_rem_d = 1'b0;
            cnt_d     = CNT_LOAD;
            state_d   = S_RUN;
          end else if ((op == OP_DIV) && (B != {W{1'b0}})) begin
            hi_d      = {W{1'b0}};
            lo_d      = mag(A);
            m_d       = mag(B);
            is_div_d  = 1'b1;
            neg_res_d = A[W-1] ^ B[W-1];
            neg_rem_d = A[W-1];
            cnt_d     = CNT_LOAD;
            state_d   = S_RUN;
          end else if (op == OP_DIV) begin
            c_d     = {A, {W{1'b1}}};
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (op > OP_NOT) begin
            c_d     = {(2*W){1'b0}};
            il_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            c_d     = {{W{1'b0}}, alu_single(op, A, B)};
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        hi_d  = nxt_hi_s;
        lo_d  = nxt_lo_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          if (is_div_q) begin
            c_d = {(neg_rem_q ? -nxt_hi_s : nxt_hi_s),
                   (neg_res_q ? -nxt_lo_s : nxt_lo_s)};
          end else begin
            c_d = neg_res_q ? -prod_s : prod_s;
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= {(SHW+1){1'b0}};
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      m_q       <= {W{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      c_q       <= {(2*W){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      il_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      il_q      <= il_d;
    end
  end

  assign C          = c_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div_zero   = dz_q;
  assign illegal_op = il_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: drivers push expected results, monitors pop on done.
// Covers W=32 and W=8 instances.
module tb_seq_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, DIV = 5'b00011;
  localparam logic [4:0] SHR = 5'b00100, SHRA = 5'b00101, SHL = 5'b00110, ROR = 5'b00111;
  localparam logic [4:0] ROL = 5'b01000, AND = 5'b01001, OR = 5'b01010, NEG = 5'b01011;
  localparam logic [4:0] NOT = 5'b01100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear;
  logic        start32, busy32, done32, dz32, il32;
  logic [4:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] c32;
  logic        start8, busy8, done8, dz8, il8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  seq_alu #(.W(32)) u_dut32 (
    .clock(clock), .clear(clear), .start(start32), .op(op32), .A(a32), .B(b32),
    .C(c32), .busy(busy32), .done(done32), .div_zero(dz32), .illegal_op(il32)
  );

  seq_alu #(.W(8)) u_dut8 (
    .clock(clock), .clear(clear), .start(start8), .op(op8), .A(a8), .B(b8),
    .C(c8), .busy(busy8), .done(done8), .div_zero(dz8), .illegal_op(il8)
  );

  typedef struct {
    logic [63:0] c;
    logic        dz;
    logic        il;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone32 = 0;
  int ndone8  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input exp_t e, input logic [63:0] c, input logic dz,
                       input logic il, input int now);
    total++;
    if (c !== e.c || dz !== e.dz || il !== e.il) begin
      bad++;
      $display("FAIL %s: got C=%h dz=%b il=%b, want C=%h dz=%b il=%b",
               e.name, c, dz, il, e.c, e.dz, e.il);
    end
    total++;
    if (now - e.issue != e.lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d, want %0d", e.name, now - e.issue, e.lat);
    end
  endtask

  // Monitor for the W=32 instance.
  always @(negedge clock) begin
    if (done32) begin
      ndone32++;
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done32: got done at cyc %0d, want none", cyc);
      end else begin
        check(q32.pop_front(), c32, dz32, il32, cyc);
      end
    end
  end

  // Monitor for the W=8 instance.
  always @(negedge clock) begin
    if (done8) begin
      ndone8++;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done8: got done at cyc %0d, want none", cyc);
      end else begin
        check(q8.pop_front(), {48'd0, c8}, dz8, il8, cyc);
      end
    end
  end

  task automatic wait_idle(input bit w8, input string name);
    int n;
    n = 0;
    while ((w8 ? busy8 : busy32) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (w8 ? busy8 : busy32) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles, want idle", name, n);
    end
  endtask

  task automatic run(input bit w8, input string name, input logic [4:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] ec, input logic edz, input logic eil,
                     input int lat);
    exp_t e;
    @(negedge clock);
    e.c = ec; e.dz = edz; e.il = eil; e.issue = cyc; e.lat = lat; e.name = name;
    if (w8) begin
      start8 = 1'b1; op8 = f; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(e);
    end else begin
      start32 = 1'b1; op32 = f; a32 = a; b32 = b;
      q32.push_back(e);
    end
    @(negedge clock);
    // Scramble inputs after the start cycle; the result must come from the latched values.
    start8 = 1'b0; start32 = 1'b0;
    a32 = ~a; b32 = ~b; op32 = ~f;
    a8 = ~a[7:0]; b8 = ~b[7:0]; op8 = ~f;
    wait_idle(w8, name);
  endtask

  int d0;

  initial begin
    clear = 1'b1;
    start32 = 1'b0; op32 = 5'd0; a32 = 32'd0; b32 = 32'd0;
    start8  = 1'b0; op8  = 5'd0; a8  = 8'd0;  b8  = 8'd0;
    repeat (2) @(negedge clock);
    total++;
    if (c32 !== 64'd0 || busy32 !== 1'b0 || done32 !== 1'b0 || dz32 !== 1'b0 || il32 !== 1'b0) begin
      bad++;
      $display("FAIL reset32: got C=%h busy=%b done=%b dz=%b il=%b, want all zero",
               c32, busy32, done32, dz32, il32);
    end
    total++;
    if (c8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || dz8 !== 1'b0 || il8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got C=%h busy=%b done=%b, want all zero", c8, busy8, done8);
    end
    clear = 1'b0;

    run(1'b0, "add",      ADD,  32'd7,        32'd5,        64'h0000_0000_0000_000C, 1'b0, 1'b0, 1);
    repeat (3) @(negedge clock);
    total++;
    if (c32 !== 64'h0000_0000_0000_000C) begin
      bad++;
      $display("FAIL hold_add: got C=%h, want %h", c32, 64'h0000_0000_0000_000C);
    end
    run(1'b0, "add_wrap", ADD,  32'hFFFF_FFFF, 32'd2,       64'h0000_0000_0000_0001, 1'b0, 1'b0, 1);
    run(1'b0, "sub",      SUB,  32'd5,        32'd7,        64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1);
    run(1'b0, "mul_neg",  MUL,  32'hFFFF_FFFD, 32'd5,       64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 33);
    run(1'b0, "mul_min",  MUL,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 33);
    run(1'b0, "mul_max",  MUL,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0, 33);
    run(1'b0, "div_pn",   DIV,  32'd17,       32'hFFFF_FFFB, 64'h0000_0002_FFFF_FFFD, 1'b0, 1'b0, 33);
    run(1'b0, "div_np",   DIV,  32'hFFFF_FFEF, 32'd5,       64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b0, 33);
    run(1'b0, "div_min",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 33);
    run(1'b0, "div_zero", DIV,  32'd5,        32'd0,        64'h0000_0005_FFFF_FFFF, 1'b1, 1'b0, 1);
    run(1'b0, "ror",      ROR,  32'h8000_0001, 32'h0000_0021, 64'h0000_0000_C000_0000, 1'b0, 1'b0, 1);
    run(1'b0, "rol",      ROL,  32'h8000_0001, 32'd4,       64'h0000_0000_0000_0018, 1'b0, 1'b0, 1);
    run(1'b0, "shra",     SHRA, 32'h8000_0000, 32'd4,       64'h0000_0000_F800_0000, 1'b0, 1'b0, 1);
    run(1'b0, "shr",      SHR,  32'h8000_0000, 32'd4,       64'h0000_0000_0800_0000, 1'b0, 1'b0, 1);
    run(1'b0, "shl",      SHL,  32'd3,        32'd4,        64'h0000_0000_0000_0030, 1'b0, 1'b0, 1);
    run(1'b0, "shl_s0",   SHL,  32'd3,        32'h0000_0020, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1);
    run(1'b0, "and",      AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 1'b0, 1'b0, 1);
    run(1'b0, "or",       OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_FFF0_FFF0, 1'b0, 1'b0, 1);
    run(1'b0, "neg",      NEG,  32'd9,        32'd1,        64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1);
    run(1'b0, "not",      NOT,  32'd9,        32'h0F0F_0F0F, 64'h0000_0000_F0F0_F0F0, 1'b0, 1'b0, 1);
    run(1'b0, "illegal1f", 5'b11111, 32'd1,   32'd2,        64'd0,                   1'b0, 1'b1, 1);
    run(1'b0, "illegal0d", 5'b01101, 32'd1,   32'd2,        64'd0,                   1'b0, 1'b1, 1);

    // Extra start during a MUL with changed operands must be ignored.
    d0 = ndone32;
    @(negedge clock);
    start32 = 1'b1; op32 = MUL; a32 = 32'hFFFF_FFFD; b32 = 32'd5;
    q32.push_back('{c: 64'hFFFF_FFFF_FFFF_FFF1, dz: 1'b0, il: 1'b0, issue: cyc, lat: 33, name: "mul_busy_start"});
    @(negedge clock);
    start32 = 1'b0;
    repeat (5) @(negedge clock);
    start32 = 1'b1; op32 = ADD; a32 = 32'd1; b32 = 32'd1;
    repeat (3) @(negedge clock);
    start32 = 1'b0;
    wait_idle(1'b0, "mul_busy_start");
    total++;
    if (ndone32 - d0 != 1) begin
      bad++;
      $display("FAIL mul_busy_start_dones: got %0d, want 1", ndone32 - d0);
    end

    // start held through the done cycle is ignored there.
    d0 = ndone32;
    @(negedge clock);
    start32 = 1'b1; op32 = ADD; a32 = 32'd7; b32 = 32'd5;
    q32.push_back('{c: 64'h0000_0000_0000_000C, dz: 1'b0, il: 1'b0, issue: cyc, lat: 1, name: "start_in_done"});
    @(negedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (ndone32 - d0 != 1 || busy32 !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: got dones=%0d busy=%b, want dones=1 busy=0", ndone32 - d0, busy32);
    end

    // clear in the middle of a DIV abandons it.
    @(negedge clock);
    start32 = 1'b1; op32 = DIV; a32 = 32'd17; b32 = 32'hFFFF_FFFB;
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    total++;
    if (c32 !== 64'd0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++;
      $display("FAIL clear_mid_div: got C=%h busy=%b done=%b, want C=0 busy=0 done=0", c32, busy32, done32);
    end
    run(1'b0, "add_after_clear", ADD, 32'd100, 32'd23, 64'h0000_0000_0000_007B, 1'b0, 1'b0, 1);

    // W=8 instance.
    run(1'b1, "mul8_neg", MUL, 32'hFD, 32'h05, 64'h0000_0000_0000_FFF1, 1'b0, 1'b0, 9);
    run(1'b1, "mul8_min", MUL, 32'h80, 32'h80, 64'h0000_0000_0000_4000, 1'b0, 1'b0, 9);
    run(1'b1, "div8_pn",  DIV, 32'h11, 32'hFB, 64'h0000_0000_0000_02FD, 1'b0, 1'b0, 9);
    run(1'b1, "div8_min", DIV, 32'h80, 32'hFF, 64'h0000_0000_0000_0080, 1'b0, 1'b0, 9);
    run(1'b1, "div8_zero", DIV, 32'h05, 32'h00, 64'h0000_0000_0000_05FF, 1'b1, 1'b0, 1);

    repeat (3) @(negedge clock);
    total++;
    if (q32.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got pending32=%0d pending8=%0d, want 0 0", q32.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
